fifo_read_stage: RTL and testbench

FIFO_READ_STAGE -- requirements
Module: fifo_read_stage

---
 rtl/fifo_read_stage.sv | 76 +++++++
 tb/tb_fifo_read_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_read_stage.sv
// Purpose: two-entry skid/prefetch stage sitting behind a registered-read circular buffer.
// Latency: an entry reaches out_data two cycles after its pop is issued, then streams at one per cycle.
// Backpressure: out_ready=0 holds out_data/out_valid stable; popping stops once held + in-flight reaches 2.
//
// Ports:
//   clk, reset          - single clock, synchronous active-low reset
//   fifo_empty          - upstream buffer empty flag
//   fifo_read_data      - upstream read data, valid the cycle after fifo_read_en
//   fifo_read_en        - pop request to the upstream buffer
//   flush               - drop every held and in-flight entry
//   out_valid/out_ready - downstream handshake, out_data is the oldest held entry
//   occupancy           - number of held entries (0..2)
module fifo_read_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_read_data,
  output logic              fifo_read_en,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [1:0]        occ;
  logic              inflight;

  logic              transfer;
  logic              capture;
  logic [1:0]        occ_after;   // occupancy once this cycle's transfer is removed
  logic [2:0]        committed;   // held + in-flight - leaving, i.e. slots already spoken for

  always_comb begin
    out_valid    = reset && (occ != 2'd0) && !flush;
    transfer     = out_valid && out_ready;
    // A read issued last cycle always lands now; flush/reset discard it in the register block.
    capture      = inflight;
    occ_after    = occ - {1'b0, transfer};
    committed    = {1'b0, occ} + {2'b00, inflight} - {2'b00, transfer};
    fifo_read_en = reset && !flush && !fifo_empty && (committed < 3'd2);
    out_data     = head;
    occupancy    = reset ? occ : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else if (flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read_en;
      occ      <= occ_after + {1'b0, capture};
      // Tail advances to head when the head leaves; the new word then lands behind it.
      if (transfer && (occ == 2'd2)) begin
        head <= tail;
      end
      if (capture) begin
        if (occ_after == 2'd0) begin
          head <= fifo_read_data;
        end else begin
          tail <= fifo_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_stage.sv
module tb_fifo_read_stage;

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        fifo_read_en;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;

  fifo_read_stage #(.DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream buffer model: registered read, data appears the cycle after a pop.
  logic [31:0] mem [0:7];
  int          n;
  int          rp;
  int          vectors;
  int          miscompares;
  int          cyc;
  string       tname;

  task automatic chk(input string what, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d %s: observed %h expected %h", tname, cyc, what, obs, exp);
    end
  endtask

  task automatic load(input string name, input int cnt, input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4);
    tname = name;
    cyc = 0;
    mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3; mem[4] = v4;
    n = cnt;
    rp = 0;
    fifo_empty = (cnt == 0);
  endtask

  // One cycle: apply inputs, check the settled outputs, then advance and model the upstream read.
  task automatic step(input logic rdy, input logic fl, input logic rst, input logic e_en,
                      input logic e_v, input logic [31:0] e_d, input logic [1:0] e_occ);
    logic popped;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    #1;
    chk("fifo_read_en", {31'b0, fifo_read_en}, {31'b0, e_en});
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_v});
    chk("occupancy", {30'b0, occupancy}, {30'b0, e_occ});
    if (e_v) chk("out_data", out_data, e_d);
    popped = fifo_read_en;
    @(posedge clk);
    @(negedge clk);
    if (popped) begin
      fifo_read_data = mem[rp];
      rp++;
    end else begin
      fifo_read_data = 32'hBAD0_BAD0;
    end
    fifo_empty = (rp >= n);
    cyc++;
  endtask

  task automatic stream4(input string name);
    load(name, 4, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0,  2'd0);
    step(1, 0, 1, 1, 0, 32'h0,  2'd0);
    step(1, 0, 1, 1, 1, 32'h11, 2'd1);
    step(1, 0, 1, 1, 1, 32'h22, 2'd1);
    step(1, 0, 1, 0, 1, 32'h33, 2'd1);
    step(1, 0, 1, 0, 1, 32'h44, 2'd1);
    step(1, 0, 1, 0, 0, 32'h0,  2'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    fifo_read_data = 32'hBAD0_BAD0;
    out_ready = 1'b0;
    flush = 1'b0;
    reset = 1'b0;

    // Held in reset with a non-empty upstream: nothing may be popped or presented.
    load("reset", 2, 32'hE0, 32'hE1, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0, 2'd0);
    step(1, 0, 0, 0, 0, 32'h0, 2'd0);
    step(1, 0, 0, 0, 0, 32'h0, 2'd0);

    stream4("stream");

    // Downstream stalled: exactly two pops, head stable, then drains in order.
    load("stall", 5, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 0, 1, 32'hA0, 2'd1);
    step(0, 0, 1, 0, 1, 32'hA0, 2'd2);
    step(0, 0, 1, 0, 1, 32'hA0, 2'd2);
    step(0, 0, 1, 0, 1, 32'hA0, 2'd2);
    step(1, 0, 1, 1, 1, 32'hA0, 2'd2);
    step(1, 0, 1, 1, 1, 32'hA1, 2'd1);
    step(1, 0, 1, 1, 1, 32'hA2, 2'd1);
    step(1, 0, 1, 0, 1, 32'hA3, 2'd1);
    step(1, 0, 1, 0, 1, 32'hA4, 2'd1);
    step(1, 0, 1, 0, 0, 32'h0,  2'd0);

    load("empty", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h0, 2'd0);
    step(1, 0, 1, 0, 0, 32'h0, 2'd0);
    step(1, 0, 1, 0, 0, 32'h0, 2'd0);

    // Flush while 0x55 is in flight and 0x50 is held: both vanish, 0x66 follows normally.
    load("flush", 3, 32'h50, 32'h55, 32'h66, 32'h0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0,  2'd0);
    step(1, 0, 1, 1, 0, 32'h0,  2'd0);
    step(1, 1, 1, 0, 0, 32'h0,  2'd1);
    step(1, 0, 1, 1, 0, 32'h0,  2'd0);
    step(1, 0, 1, 0, 0, 32'h0,  2'd0);
    step(1, 0, 1, 0, 1, 32'h66, 2'd1);
    step(1, 0, 1, 0, 0, 32'h0,  2'd0);

    // Full stage released while the next word is fetched: order 01, 02, 03.
    load("xfer_capture", 3, 32'h01, 32'h02, 32'h03, 32'h0, 32'h0);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 0, 1, 32'h01, 2'd1);
    step(1, 0, 1, 1, 1, 32'h01, 2'd2);
    step(1, 0, 1, 0, 1, 32'h02, 2'd1);
    step(1, 0, 1, 0, 1, 32'h03, 2'd1);
    step(1, 0, 1, 0, 0, 32'h0,  2'd0);

    // Reset lands while a read is in flight: the returning word must be dropped.
    load("reset_inflight", 2, 32'hD0, 32'hD1, 32'h0, 32'h0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0, 2'd0);
    step(1, 0, 0, 0, 0, 32'h0, 2'd0);
    load("reset_inflight", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h0, 2'd0);
    step(1, 0, 1, 0, 0, 32'h0, 2'd0);

    // Reset mid-stall with two held entries, then streaming resumes.
    load("reset_stall", 3, 32'hC0, 32'hC1, 32'hC2, 32'h0, 32'h0);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 1, 0, 32'h0,  2'd0);
    step(0, 0, 1, 0, 1, 32'hC0, 2'd1);
    step(0, 0, 1, 0, 1, 32'hC0, 2'd2);
    step(0, 0, 0, 0, 0, 32'h0,  2'd0);
    stream4("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
